// File: rtl/data_mem_sb.sv
// Data memory for the single-cycle MIPS core: 2^AW x DW single-port array behind a
// DEPTH-entry FIFO store buffer that drains only on idle cycles or when a store finds it full.
module data_mem_sb #(
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     CEN,
    input  logic                     WEN,
    input  logic                     OEN,
    input  logic [AW-1:0]            A,
    input  logic [DW-1:0]            Data2Mem,
    output logic [DW-1:0]            ReadDataMem,
    output logic [$clog2(DEPTH):0]   sb_count,
    input  logic [AW-1:0]            dbg_addr,
    output logic [DW-1:0]            dbg_data
);

    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned CW     = PW + 1;
    localparam int unsigned NWORDS = 1 << AW;

    logic [DW-1:0] mem_q     [NWORDS];
    logic [AW-1:0] sb_addr_q [DEPTH];
    logic [DW-1:0] sb_data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic is_store, is_load, is_idle, full, empty, drain;
    logic [DW-1:0] rd_fwd, dbg_fwd;
    logic [PW-1:0] idx;

    assign is_store = !CEN && !WEN;
    assign is_load  = !CEN && WEN && !OEN;
    assign is_idle  = !is_store && !is_load;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign drain    = (is_idle && !empty) || (is_store && full);

    // Walk oldest to youngest so the last matching entry (the youngest) wins.
    always_comb begin
        rd_fwd  = mem_q[A];
        dbg_fwd = mem_q[dbg_addr];
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (sb_addr_q[idx] == A)        rd_fwd  = sb_data_q[idx];
                if (sb_addr_q[idx] == dbg_addr) dbg_fwd = sb_data_q[idx];
            end
        end
    end

    assign ReadDataMem = is_load ? rd_fwd : '0;
    assign dbg_data    = dbg_fwd;
    assign sb_count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain)    head_d = head_q + PW'(1);
        if (is_store) tail_d = tail_q + PW'(1);
        if (is_store && !full)
            count_d = count_q + CW'(1);
        else if (is_idle && !empty)
            count_d = count_q - CW'(1);
    end

    // When full, head == tail: the drained slot is refilled by the incoming store on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NWORDS; i++) mem_q[i] <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                sb_addr_q[j] <= '0;
                sb_data_q[j] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (drain) mem_q[sb_addr_q[head_q]] <= sb_data_q[head_q];
            if (is_store) begin
                sb_addr_q[tail_q] <= A;
                sb_data_q[tail_q] <= Data2Mem;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_data_mem_sb.sv
// Scoreboard bench for data_mem_sb: stimulus queues expected values, a negedge monitor compares.
module tb_data_mem_sb;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    localparam int K_RD  = 0;
    localparam int K_CNT = 1;
    localparam int K_DBG = 2;
    localparam int K_MEM = 3;

    logic          clk;
    logic          rst_n;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] Data2Mem;
    logic [DW-1:0] ReadDataMem;
    logic [2:0]    sb_count;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    typedef struct {
        string       name;
        int          kind;
        int          addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    data_mem_sb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN),
        .A(A), .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem),
        .sb_count(sb_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every negedge, consume whatever the stimulus queued for this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_RD:    act = ReadDataMem;
                K_CNT:   act = {29'd0, sb_count};
                K_DBG:   act = dbg_data;
                default: act = dut.mem_q[e.addr];
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic chk(input string name, input int kind, input int addr, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.addr = addr; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic c, input logic w, input logic o,
                         input int a, input logic [31:0] d);
        CEN = c; WEN = w; OEN = o; A = AW'(a); Data2Mem = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();  drive(1'b1, 1'b1, 1'b1, 0, 32'h0); endtask
    task automatic store(input int a, input logic [31:0] d); drive(1'b0, 1'b0, 1'b1, a, d); endtask
    task automatic load(input int a); drive(1'b0, 1'b1, 1'b0, a, 32'h0); endtask

    initial begin
        rst_n = 1'b0;
        dbg_addr = '0;
        idle();
        step(); step();
        rst_n = 1'b1;

        // Reset state and non-load read-data behaviour
        load(5);                               chk("rst_load5", K_RD, 0, 32'h0); chk("rst_cnt", K_CNT, 0, 32'd0); step();
        drive(1'b1, 1'b1, 1'b0, 5, 32'h0);     chk("cen1_rd", K_RD, 0, 32'h0); step();
        drive(1'b0, 1'b0, 1'b0, 3, 32'hDEADBEEF); chk("store_oen0_rd", K_RD, 0, 32'h0); chk("cnt_pre_st3", K_CNT, 0, 32'd0); step();

        // Store then immediate load forwards from the buffer
        dbg_addr = 7'd3;
        load(3);  chk("fwd_ld3", K_RD, 0, 32'hDEADBEEF); chk("cnt_after_st3", K_CNT, 0, 32'd1);
                  chk("mem3_undrained", K_MEM, 3, 32'h0); chk("dbg3_fwd", K_DBG, 0, 32'hDEADBEEF); step();
        idle();   chk("idle_rd", K_RD, 0, 32'h0); chk("cnt_before_drain", K_CNT, 0, 32'd1); step();

        // Same-address stores stay separate; youngest wins
        store(7, 32'd1); chk("cnt_drained", K_CNT, 0, 32'd0); chk("mem3_drained", K_MEM, 3, 32'hDEADBEEF); step();
        store(7, 32'd2); chk("cnt_st7a", K_CNT, 0, 32'd1); step();
        load(7);         chk("ld7_youngest", K_RD, 0, 32'd2); chk("cnt_st7b", K_CNT, 0, 32'd2); step();
        dbg_addr = 7'd7;
        idle();          chk("cnt_ld_nodrain", K_CNT, 0, 32'd2); step();
        idle();          chk("cnt_one_drain", K_CNT, 0, 32'd1); chk("mem7_first", K_MEM, 7, 32'd1);
                         chk("dbg7_fwd", K_DBG, 0, 32'd2); step();
        idle();          chk("cnt_empty", K_CNT, 0, 32'd0); chk("mem7_final", K_MEM, 7, 32'd2);
                         chk("dbg7_array", K_DBG, 0, 32'd2); step();

        // Five stores into a 4-entry buffer: fifth edge drains the head
        for (int k = 0; k < 5; k++) begin
            store(k, 32'h10 + 32'(k));
            chk($sformatf("cnt_fill%0d", k), K_CNT, 0, (k < 4) ? 32'(k) : 32'd4);
            if (k == 4) chk("mem0_pre_full", K_MEM, 0, 32'h0);
            step();
        end
        dbg_addr = 7'd0;
        load(1);  chk("cnt_full_hold", K_CNT, 0, 32'd4); chk("mem0_full_drain", K_MEM, 0, 32'h10);
                  chk("mem1_not_yet", K_MEM, 1, 32'h0); chk("ld1_fwd", K_RD, 0, 32'h11);
                  chk("dbg0_array", K_DBG, 0, 32'h10); step();
        for (int k = 0; k < 4; k++) begin
            idle(); chk($sformatf("cnt_drain%0d", k), K_CNT, 0, 32'(4 - k)); step();
        end
        idle(); chk("cnt_drain_done", K_CNT, 0, 32'd0);
        for (int k = 0; k < 5; k++) chk($sformatf("mem%0d_final", k), K_MEM, k, 32'h10 + 32'(k));
        step();

        // Loads never drain
        store(10, 32'hA0); step();
        store(11, 32'hA1); step();
        store(12, 32'hA2); step();
        load(10); chk("ldonly_cnt0", K_CNT, 0, 32'd3); chk("ld10", K_RD, 0, 32'hA0); step();
        load(11); chk("ldonly_cnt1", K_CNT, 0, 32'd3); chk("ld11", K_RD, 0, 32'hA1); step();
        load(12); chk("ldonly_cnt2", K_CNT, 0, 32'd3); chk("ld12", K_RD, 0, 32'hA2); step();
        load(13); chk("ldonly_cnt3", K_CNT, 0, 32'd3); chk("ld13_array", K_RD, 0, 32'h0); step();
        idle();   chk("ldonly_cnt4", K_CNT, 0, 32'd3); step();
        store(20, 32'hB0); chk("idle_drain_cnt", K_CNT, 0, 32'd2); chk("mem10_drained", K_MEM, 10, 32'hA0); step();

        // Asynchronous reset mid-cycle with 3 entries buffered
        dbg_addr = 7'd20;
        load(20);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_cnt", K_CNT, 0, 32'd0);
        chk("rst_async_dbg20", K_DBG, 0, 32'h0);
        chk("rst_async_ld20", K_RD, 0, 32'h0);
        step();
        idle();
        for (int i = 0; i < (1 << AW); i++) begin
            dbg_addr = AW'(i);
            #1 chk($sformatf("rst_dbg%0d", i), K_DBG, 0, 32'h0);
            step();
        end
        rst_n = 1'b1;

        store(5, 32'h55); step();
        load(5); chk("post_rst_ld5", K_RD, 0, 32'h55); chk("post_rst_cnt", K_CNT, 0, 32'd1); step();
        idle(); step(); step();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
